// File: rtl/sequence_player.sv
// sequence_player: plays a stored LED colour sequence with programmable on/off timing
// Ports: clk, rst_n      - clock and asynchronous active-low reset
//        start/abort     - begin playback when idle / stop playback at once
//        speed, length   - timing select and item count, latched when start is accepted
//        mem_rd/mem_addr - one-cycle read strobe and address into the sequence memory
//        mem_data        - sequence item, valid the cycle after mem_rd
//        led             - registered LED drive, nonzero only while an item is lit
//        busy, done      - playback in progress / one-cycle completion pulse
module sequence_player #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int ON_SLOW    = 50,
  parameter int OFF_SLOW   = 25,
  parameter int ON_FAST    = 20,
  parameter int OFF_FAST   = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  speed,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] led,
  output logic                  busy,
  output logic                  done
);
  localparam int MAX_ON  = ON_SLOW > ON_FAST ? ON_SLOW : ON_FAST;
  localparam int MAX_OFF = OFF_SLOW > OFF_FAST ? OFF_SLOW : OFF_FAST;
  localparam int MAX_CNT = MAX_ON > MAX_OFF ? MAX_ON : MAX_OFF;
  localparam int CW      = $clog2(MAX_CNT + 1);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, LED_ON, LED_OFF, DONE} state_t;
  state_t                r_state, w_next;
  logic                  r_speed;
  logic [ADDR_WIDTH-1:0] r_len, r_index;
  logic [CW-1:0]         r_cnt, w_on, w_off;
  logic [DATA_WIDTH-1:0] r_led;
  logic                  w_accept, w_last;
  assign w_accept = r_state == IDLE && start && !abort;
  // Counters run from N-1 down to 0, so a phase lasts exactly N cycles.
  assign w_on     = r_speed ? CW'(ON_FAST - 1) : CW'(ON_SLOW - 1);
  assign w_off    = r_speed ? CW'(OFF_FAST - 1) : CW'(OFF_SLOW - 1);
  assign w_last   = r_index == r_len - ADDR_WIDTH'(1);
  // The index only moves on entry to FETCH, so it doubles as the held read address.
  assign mem_addr = r_index;
  assign mem_rd   = r_state == FETCH;
  assign busy     = r_state inside {FETCH, WAIT_DATA, LED_ON, LED_OFF};
  assign done     = r_state == DONE;
  assign led      = r_led;
  always_comb begin
    w_next = r_state;
    if (abort) w_next = IDLE;
    else
      case (r_state)
        IDLE:      if (start) w_next = length == '0 ? DONE : FETCH;
        FETCH:     w_next = WAIT_DATA;
        WAIT_DATA: w_next = LED_ON;
        LED_ON:    if (r_cnt == '0) w_next = LED_OFF;
        LED_OFF:   if (r_cnt == '0) w_next = w_last ? DONE : FETCH;
        default:   w_next = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_speed <= 1'b0;
      r_len   <= '0;
      r_index <= '0;
      r_cnt   <= '0;
      r_led   <= '0;
    end else begin
      if (w_accept) begin
        r_speed <= speed;
        r_len   <= length;
      end
      r_index <= w_accept ? '0 : (r_state == LED_OFF && w_next == FETCH) ? r_index + ADDR_WIDTH'(1) : r_index;
      // Dark everywhere except LED_ON, which also blanks the LED on abort.
      r_led   <= w_next != LED_ON ? '0 : r_state == WAIT_DATA ? mem_data : r_led;
      r_cnt   <= r_state == WAIT_DATA ? w_on : (r_state == LED_ON && r_cnt == '0) ? w_off :
                 r_cnt != '0 ? r_cnt - CW'(1) : r_cnt;
    end
endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: directed table, random scenarios and reset corners against a cycle model
module tb_sequence_player;
  localparam int DW = 4, AW = 6, ONS = 4, OFFS = 2, ONF = 2, OFFF = 1;
  logic          clk = 0, rst_n = 0, start = 0, abort = 0, speed = 0;
  logic [AW-1:0] length = '0;
  logic          mem_rd, busy, done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data = '0, led;
  logic [DW-1:0] mem [64];
  int            n_tests = 0, n_fail = 0, exp_addr = 0;
  typedef struct {
    bit            spd;
    int            len, ab, rs, fl, nc;
    logic [DW-1:0] m0, m1, m2;
    int            e_done, e_rd, e_led, e_busy;
  } vec_t;
  vec_t tbl [8];
  sequence_player #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .ON_SLOW(ONS), .OFF_SLOW(OFFS), .ON_FAST(ONF), .OFF_FAST(OFFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .speed(speed), .length(length),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .led(led), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  // Cycle 0 is the cycle start is high; item k occupies cycles 1+k*P .. k*P+P with
  // P=ON+OFF+2: read at offset 0, lit at offsets 2..ON+1; done at 1+len*P.
  task automatic run(input bit spd, input int len, ab, rs, fl, nc,
                     output int o_done, o_rd, o_led, o_busy);
    int on, p, fin, k, ph;
    bit alive;
    logic e_rd, e_busy, e_done;
    logic [DW-1:0] e_led;
    on  = spd ? ONF : ONS;
    p   = on + (spd ? OFFF : OFFS) + 2;
    fin = len == 0 ? 1 : 1 + len * p;
    o_done = -1; o_rd = 0; o_led = -1; o_busy = 0;
    for (int c = 0; c <= nc; c++) begin
      @(posedge clk); #1;
      start = c == 0 || c == rs;
      abort = c == ab;
      if (c == 0) begin speed = spd; length = AW'(len); end
      if (c == fl) begin speed = ~speed; length = AW'($urandom); end
      alive  = ab < 0 || c <= ab;
      e_busy = alive && c >= 1 && c < fin;
      e_done = alive && c == fin;
      e_rd   = 1'b0;
      e_led  = '0;
      if (e_busy) begin
        k  = (c - 1) / p;
        ph = (c - 1) % p;
        e_rd = ph == 0;
        if (ph >= 2 && ph < 2 + on) e_led = mem[k];
        if (e_rd) exp_addr = k;
      end
      check($sformatf("cycle %0d {rd,addr,led,busy,done}", c), int'({mem_rd, mem_addr, led, busy, done}),
            int'({e_rd, AW'(exp_addr), e_led, e_busy, e_done}));
      if (done && o_done < 0) o_done = c;
      if (mem_rd) o_rd++;
      if (led != '0 && o_led < 0) o_led = c;
      if (busy) o_busy++;
    end
    start = 0;
    abort = 0;
  endtask
  initial begin
    int od, ord, ol, ob, len, ab, rs, fl, nc, fin, p;
    bit spd, seen;
    for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
    tbl[0] = '{1'b0, 3, -1, -1, -1, 27, 4'h1, 4'h4, 4'h8, 25, 3, 3, 24};
    tbl[1] = '{1'b1, 1, -1, -1, -1, 8, 4'h2, 4'h0, 4'h0, 6, 1, 3, 5};
    tbl[2] = '{1'b0, 0, -1, -1, -1, 3, 4'h0, 4'h0, 4'h0, 1, 0, -1, 0};
    tbl[3] = '{1'b0, 3, 12, -1, -1, 14, 4'h1, 4'h4, 4'h8, -1, 2, 3, 12};
    tbl[4] = '{1'b0, 3, -1, -1, -1, 27, 4'h1, 4'h4, 4'h8, 25, 3, 3, 24};
    tbl[5] = '{1'b0, 2, -1, 5, 6, 19, 4'h6, 4'h9, 4'h0, 17, 2, 3, 16};
    tbl[6] = '{1'b1, 2, -1, -1, -1, 13, 4'h0, 4'h3, 4'h0, 11, 2, 8, 10};
    tbl[7] = '{1'b1, 63, -1, -1, -1, 318, 4'h5, 4'h7, 4'h9, 316, 63, 3, 315};
    repeat (2) @(posedge clk);
    #1 check("reset outputs", int'({mem_rd, mem_addr, led, busy, done}), 0);
    rst_n = 1;
    for (int t = 0; t < 8; t++) begin
      mem[0] = tbl[t].m0; mem[1] = tbl[t].m1; mem[2] = tbl[t].m2;
      run(tbl[t].spd, tbl[t].len, tbl[t].ab, tbl[t].rs, tbl[t].fl, tbl[t].nc, od, ord, ol, ob);
      check($sformatf("vec %0d done cycle", t), od, tbl[t].e_done);
      check($sformatf("vec %0d read count", t), ord, tbl[t].e_rd);
      check($sformatf("vec %0d first led cycle", t), ol, tbl[t].e_led);
      check($sformatf("vec %0d busy cycles", t), ob, tbl[t].e_busy);
    end
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 8; i++) mem[i] = DW'($urandom);
      spd = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 6);
      p   = (spd ? ONF + OFFF : ONS + OFFS) + 2;
      fin = len == 0 ? 1 : 1 + len * p;
      ab  = (len > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, fin - 1) : -1;
      rs  = len > 0 ? $urandom_range(1, ab >= 0 ? ab : fin - 1) : -1;
      nc  = ab >= 0 ? ab + 2 : fin + 2;
      fl  = $urandom_range(1, nc);
      run(spd, len, ab, rs, fl, nc, od, ord, ol, ob);
    end
    @(posedge clk); #1 start = 1; abort = 1;
    @(posedge clk); #1 start = 0; abort = 0;
    check("abort with start in idle", int'({mem_rd, busy, done}), 0);
    @(posedge clk); #1 check("idle after abort+start", int'({mem_rd, busy, done}), 0);
    mem[0] = 4'h9; speed = 0; length = AW'(3);
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    repeat (3) @(posedge clk);
    #1 check("led lit before reset", int'(led), 9);
    #2 rst_n = 0;
    #1 check("async reset mid-play", int'({mem_rd, mem_addr, led, busy, done}), 0);
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || busy || led != '0) seen = 1;
    end
    check("quiet while in reset", int'(seen), 0);
    #3 rst_n = 1; start = 1;
    @(posedge clk); #1 start = 0;
    check("start on first edge after reset", int'({mem_rd, mem_addr, busy}), int'({1'b1, 6'd0, 1'b1}));
    abort = 1;
    @(posedge clk); #1 abort = 0;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    check("no done after reset and abort", int'(seen), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
